// File: rtl/freqdiv_pkg.sv
// ---------------------------------------------------------------------------
// freqdiv_pkg
//   Shared types and constants for the runtime-programmable clock divider.
//
//   state_t : configuration controller states
//             IDLE - ready to accept a new ratio
//             PEND - a validated ratio waits for the next period boundary
//   MIN_DIV : smallest legal divide ratio; smaller requests are rejected
// ---------------------------------------------------------------------------
package freqdiv_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    PEND = 1'b1
  } state_t;

  localparam int MIN_DIV = 2;

endpackage : freqdiv_pkg

// File: rtl/freqdiv_ctrl_if.sv
// ---------------------------------------------------------------------------
// freqdiv_ctrl_if
//   Configuration handshake and status bundle for freqdiv_ctrl.
//
//   cfg_valid : request valid (master -> slave)
//   cfg_div   : requested divide ratio, W bits (master -> slave)
//   cfg_ready : controller can accept a request (slave -> master)
//   busy      : a validated ratio is waiting to be applied (slave -> master)
//   upd_done  : one-cycle pulse on the edge that applies a ratio
//   err       : one-cycle pulse when a ratio below the minimum is rejected
//   div_cur   : ratio currently in effect
//
//   master : configuration source
//   slave  : freqdiv_ctrl
// ---------------------------------------------------------------------------
interface freqdiv_ctrl_if #(
  parameter int W = 8
) ();

  logic         cfg_valid;
  logic [W-1:0] cfg_div;
  logic         cfg_ready;
  logic         busy;
  logic         upd_done;
  logic         err;
  logic [W-1:0] div_cur;

  modport master (
    output cfg_valid,
    output cfg_div,
    input  cfg_ready,
    input  busy,
    input  upd_done,
    input  err,
    input  div_cur
  );

  modport slave (
    input  cfg_valid,
    input  cfg_div,
    output cfg_ready,
    output busy,
    output upd_done,
    output err,
    output div_cur
  );

endinterface : freqdiv_ctrl_if

// File: rtl/int_freqdiv_core.sv
// ---------------------------------------------------------------------------
// int_freqdiv_core
//   Integer divider datapath. Produces a registered divided clock whose
//   period is `div` input cycles: floor(div/2) cycles high, then the rest low.
//
//   CLK_in  : processing clock
//   RST     : asynchronous active-low reset
//   SYNC    : enable; low holds CLK_out low and clears the period counter
//   div     : ratio in effect (caller guarantees div >= 2)
//   load    : a new ratio takes effect at this edge; restarts the period
//   CLK_out : divided clock, registered
//   last    : current cycle is the final cycle of a period (period boundary)
// ---------------------------------------------------------------------------
module int_freqdiv_core #(
  parameter int W = 8
) (
  input  logic         CLK_in,
  input  logic         RST,
  input  logic         SYNC,
  input  logic [W-1:0] div,
  input  logic         load,
  output logic         CLK_out,
  output logic         last
);

  localparam logic [W-1:0] ONE = W'(1);

  logic [W-1:0] cnt;
  logic [W-1:0] half;

  assign half = div >> 1;

  // div >= 2 always holds, so div - 1 cannot wrap.
  assign last = SYNC && (cnt == (div - ONE));

  always_ff @(posedge CLK_in or negedge RST) begin
    if (!RST) begin
      cnt     <= '0;
      CLK_out <= 1'b0;
    end else if (!SYNC) begin
      cnt     <= '0;
      CLK_out <= 1'b0;
    end else begin
      // High phase is judged against the ratio in effect this cycle; a load
      // lands on a boundary where the old ratio already drives CLK_out low.
      CLK_out <= (cnt < half);
      cnt     <= (load || last) ? '0 : (cnt + ONE);
    end
  end

endmodule : int_freqdiv_core

// File: rtl/freqdiv_ctrl.sv
// ---------------------------------------------------------------------------
// freqdiv_ctrl
//   Runtime-programmable integer clock divider with a configuration
//   controller. New ratios arrive over a valid/ready handshake and are only
//   applied at a divided-clock period boundary (or while SYNC is low), so
//   CLK_out never produces a runt pulse.
//
//   CLK_in  : processing clock
//   RST     : asynchronous active-low reset
//   SYNC    : divider enable; low holds CLK_out low and clears the counter
//   cfg     : configuration handshake / status (freqdiv_ctrl_if.slave)
//   CLK_out : divided clock, registered
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | cfg_ready=1; a request below MIN_DIV pulses err, otherwise it
//         | is latched into div_pend and the FSM moves to PEND
//   PEND  | busy=1, requests ignored; on a period boundary or any SYNC=0
//         | cycle the pending ratio is applied, upd_done pulses, back to IDLE
// ---------------------------------------------------------------------------
module freqdiv_ctrl
  import freqdiv_pkg::*;
#(
  parameter int W       = 8,
  parameter int DIV_RST = 2
) (
  input  logic           CLK_in,
  input  logic           RST,
  input  logic           SYNC,
  freqdiv_ctrl_if.slave  cfg,
  output logic           CLK_out
);

  localparam logic [W-1:0] DIV_RST_W = W'(DIV_RST);
  localparam logic [W-1:0] MIN_DIV_W = W'(MIN_DIV);

  state_t       state;
  state_t       state_nxt;
  logic [W-1:0] div_pend;
  logic [W-1:0] div_cur;
  logic         upd_done_q;
  logic         err_q;

  logic         accept;
  logic         reject;
  logic         apply;
  logic         last;

  always_ff @(posedge CLK_in or negedge RST) begin
    if (!RST) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    reject    = 1'b0;
    apply     = 1'b0;
    unique case (state)
      IDLE: begin
        if (cfg.cfg_valid) begin
          if (cfg.cfg_div < MIN_DIV_W) begin
            reject = 1'b1;
          end else begin
            accept    = 1'b1;
            state_nxt = PEND;
          end
        end
      end
      PEND: begin
        // With SYNC low the output is already parked low, so applying the
        // ratio right away cannot clip a pulse.
        if (!SYNC || last) begin
          apply     = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK_in or negedge RST) begin
    if (!RST) begin
      div_pend   <= DIV_RST_W;
      div_cur    <= DIV_RST_W;
      upd_done_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      upd_done_q <= apply;
      err_q      <= reject;
      if (accept) begin
        div_pend <= cfg.cfg_div;
      end
      if (apply) begin
        div_cur <= div_pend;
      end
    end
  end

  int_freqdiv_core #(
    .W (W)
  ) u_core (
    .CLK_in  (CLK_in),
    .RST     (RST),
    .SYNC    (SYNC),
    .div     (div_cur),
    .load    (apply),
    .CLK_out (CLK_out),
    .last    (last)
  );

  assign cfg.cfg_ready = (state == IDLE);
  assign cfg.busy      = (state == PEND);
  assign cfg.upd_done  = upd_done_q;
  assign cfg.err       = err_q;
  assign cfg.div_cur   = div_cur;

endmodule : freqdiv_ctrl
